// File: rtl/npc_pipe_pkg.sv
// Shared definitions for the NPC inter-stage pipeline slices: depth limit,
// count-width helper and per-stage payload widths.
package npc_pipe_pkg;

  localparam int PIPE_DEPTH_MAX = 16;

  localparam int XSTAGE_W = 96;
  localparam int MSTAGE_W = 72;
  localparam int WSTAGE_W = 40;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slice_ptr.sv
// Wrapping buffer pointer: counts 0..DEPTH-1 and returns to 0; clr has
// priority over inc.
module pipe_slice_ptr #(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (inc)
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_slice.sv
// Valid/ready pipeline slice built on a DEPTH-entry circular buffer with flush.
// Define CONFIG_PIPE_SLICE_FALLTHROUGH_EN for zero-latency pass-through when empty.
module pipe_slice
  import npc_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = cw(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             empty, full, enq, deq, bypass, wr_en, rd_inc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // s_ready never looks at m_ready, keeping the downstream stall path registered.
  assign s_ready = !full & !flush;

`ifdef CONFIG_PIPE_SLICE_FALLTHROUGH_EN
  assign m_valid = (empty ? s_valid : 1'b1) & !flush;
  assign m_data  = empty ? s_data : mem_q[rd_ptr];
  assign bypass  = empty & enq & deq;
`else
  assign m_valid = !empty & !flush;
  assign m_data  = mem_q[rd_ptr];
  assign bypass  = 1'b0;
`endif

  assign enq = s_valid & s_ready;
  assign deq = m_valid & m_ready;

  // A bypassed payload never touches storage, so neither pointer moves.
  assign wr_en  = enq & !bypass;
  assign rd_inc = deq & !bypass;

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else
      count_d = count_q + CW'(wr_en) - CW'(rd_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= s_data;
    end
  end

  pipe_slice_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  pipe_slice_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_inc),
    .ptr   (rd_ptr)
  );

  assign count = count_q;

endmodule
